// File: rtl/spi_bus_bridge.sv
// SPI slave (idle-high sck, sample on rise) bridging frames to a simple bus.
// A frame is a header word, then data words sent low byte first, MSB first.
module spi_bus_bridge #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    output logic                  bus_wr,
    output logic                  bus_rd,
    input  logic [DATA_WIDTH-1:0] bus_rd_data,
    output logic                  frame_err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [4:0]       FLUSH_N  = 5'(SYNC_STAGES);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HDR      = 2'd1;
    localparam logic [1:0] RD_FETCH = 2'd2;
    localparam logic [1:0] XFER     = 2'd3;

    // Wire order puts byte 0 first; reversing bytes maps wire order <-> natural order.
    function automatic logic [DATA_WIDTH-1:0] byte_swap(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++) r[8*i +: 8] = w[DATA_WIDTH-8-8*i +: 8];
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_p0, ss_p0, mosi_p0;
    logic                   sck_p1, ss_p1;
    logic [4:0]             flush_cnt;
    logic                   armed;

    logic [1:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  rnw, autoinc;
    logic                  miso_q;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic                  rd_cap;

    logic [DATA_WIDTH-1:0] rx_shift, rx_word;
    logic [DATA_WIDTH-1:0] tx_shift, next_word, rd_swapped;

    logic sck_rise, sck_fall, ss_fall, ss_rise, frame_end;

    // Stage p0: synchronisers, loaded with the idle bus levels on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '1;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_p1    <= 1'b1;
            ss_p1     <= 1'b1;
        end else begin
            sck_sync[0]  <= sck;
            ss_sync[0]   <= ss;
            mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                ss_sync[i]   <= ss_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sck_p1 <= sck_p0;
            ss_p1  <= ss_p0;
        end
    end

    assign sck_p0  = sck_sync[SYNC_STAGES-1];
    assign ss_p0   = ss_sync[SYNC_STAGES-1];
    assign mosi_p0 = mosi_sync[SYNC_STAGES-1];

    // A reset taken mid-frame must not see the still-low ss as a fresh fall:
    // frames are only accepted once ss has been observed high after the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else if (flush_cnt != FLUSH_N) begin
            flush_cnt <= flush_cnt + 5'd1;
        end else if (ss_p0) begin
            armed <= 1'b1;
        end
    end

    // Stage p1: edge detection in the clk domain
    assign sck_rise  = sck_p0 & ~sck_p1;
    assign sck_fall  = ~sck_p0 & sck_p1;
    assign ss_fall   = ~ss_p0 & ss_p1 & armed;
    assign ss_rise   = ss_p0 & ~ss_p1;
    assign frame_end = (state != IDLE) && (ss_rise || ss_fall);

    assign rx_word    = {rx_shift[DATA_WIDTH-2:0], mosi_p0};
    assign rd_swapped = byte_swap(bus_rd_data);
    assign rd_cap     = rd_pipe[RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (sck_rise) rx_shift <= rx_word;
    end

    // Transmit path: current word shifts on rises; the prefetched word loads at the boundary
    always_ff @(posedge clk) begin
        if (rd_cap && state == RD_FETCH)
            tx_shift <= rd_swapped;
        else if (state == XFER && sck_rise)
            tx_shift <= (bit_cnt == LAST_BIT) ? next_word : (tx_shift << 1);
        if (rd_cap && state == XFER)
            next_word <= rd_swapped;
    end

    // Stage p2: frame control and bus strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            bus_wr      <= 1'b0;
            bus_rd      <= 1'b0;
            miso_q      <= 1'b0;
            frame_err   <= 1'b0;
            rnw         <= 1'b0;
            autoinc     <= 1'b0;
            rd_pipe     <= '0;
        end else begin
            bus_wr    <= 1'b0;
            bus_rd    <= 1'b0;
            frame_err <= 1'b0;
            rd_pipe[0] <= bus_rd;
            for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];

            if ((bus_wr || bus_rd) && autoinc) bus_addr <= bus_addr + ADDR_WIDTH'(1);

            if (frame_end) begin
                frame_err <= (bit_cnt != '0);
                state     <= IDLE;
                bit_cnt   <= '0;
                miso_q    <= 1'b0;
            end

            if (ss_fall) begin
                state   <= HDR;
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end else if (!frame_end) begin
                case (state)
                    HDR: begin
                        if (sck_rise) begin
                            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                rnw      <= rx_word[0];
                                autoinc  <= rx_word[1];
                                bus_addr <= rx_word[ADDR_WIDTH+1:2];
                                if (rx_word[0]) begin
                                    state  <= RD_FETCH;
                                    bus_rd <= 1'b1;
                                end else begin
                                    state <= XFER;
                                end
                            end
                        end
                    end
                    RD_FETCH: begin
                        if (rd_cap) begin
                            miso_q <= rd_swapped[DATA_WIDTH-1];
                            state  <= XFER;
                        end
                    end
                    XFER: begin
                        if (sck_rise) begin
                            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
                            // Prefetch on the first bit so the next word is ready at the boundary
                            if (rnw && bit_cnt == '0) bus_rd <= 1'b1;
                            if (!rnw && bit_cnt == LAST_BIT) begin
                                bus_wr      <= 1'b1;
                                bus_wr_data <= byte_swap(rx_word);
                            end
                        end
                        if (sck_fall && rnw) miso_q <= tx_shift[DATA_WIDTH-1];
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign miso_oe = (state != IDLE);
    assign miso    = miso_q & miso_oe;

endmodule

// File: doc/spi_bus_bridge.md
SPI_BUS_BRIDGE -- requirements
Module: spi_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width; SHALL be a multiple of 8, range 16..32.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for sck/ss/mosi.
REQ-004 SHALL have parameter RD_LATENCY, default 1, clocks from bus_rd to valid bus_rd_data.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 sck  input  1  SPI clock, idle high; MOSI sampled on rising edge.
REQ-008 ss  input  1  SPI select, active-low.
REQ-009 mosi  input  1  SPI serial data in.
REQ-010 miso  output  1  SPI serial data out.
REQ-011 miso_oe  output  1  high while the frame is selected (synchronised ss low).
REQ-012 bus_addr  output  ADDR_WIDTH  bus address.
REQ-013 bus_wr_data  output  DATA_WIDTH  write data.
REQ-014 bus_wr  output  1  one-clock write strobe.
REQ-015 bus_rd  output  1  one-clock read strobe.
REQ-016 bus_rd_data  input  DATA_WIDTH  read data, valid RD_LATENCY clocks after bus_rd.
REQ-017 frame_err  output  1  one-clock pulse on aborted frame.

Function
REQ-018 sck, ss, mosi SHALL pass SYNC_STAGES flops; edges SHALL be detected in the clk domain; host sck half-period SHALL be at least SYNC_STAGES+2 clk cycles.
REQ-019 First word of a frame SHALL be a header of DATA_WIDTH bits, MSB first: bit 0 = RnW (1 = read), bit 1 = autoinc, bits [ADDR_WIDTH+1:2] = start address; remaining upper bits ignored.
REQ-020 Data words SHALL travel low byte first: wire order byte0 (bits 7:0) first, each byte MSB first; bridge SHALL reassemble to natural order.
REQ-021 FSM states: IDLE, HDR, RD_FETCH, XFER; IDLE->HDR on ss fall; HDR->RD_FETCH (read) or XFER (write) after DATA_WIDTH-th rising sck; RD_FETCH->XFER when read data captured; XFER->XFER on each completed word; any state->IDLE on ss rise.
REQ-022 Write: on DATA_WIDTH-th rising sck of a data word, bus_wr SHALL pulse for exactly one clock with bus_addr and reassembled bus_wr_data, within 2 clocks of the detected edge.
REQ-023 Read: bus_rd SHALL pulse one clock after header completion; data SHALL be captured RD_LATENCY clocks later into the shift register; first miso bit SHALL be driven before the next sck fall.
REQ-024 miso SHALL update on detected sck falling edges; SHALL be 0 when miso_oe is low.
REQ-025 Burst reads: next word SHALL be fetched (bus_rd pulse) while the current word shifts, no later than the 8th bit of the current word.
REQ-026 autoinc=1: bus_addr SHALL increment by 1 after each word, modulo 2^ADDR_WIDTH (all-ones wraps to 0); autoinc=0: address SHALL stay fixed for the whole frame.
REQ-027 ss rise with a partial word (bit count not 0) SHALL discard it, issue no bus_wr, pulse frame_err once; ss rise on a word boundary SHALL not pulse frame_err.
REQ-028 Header-only frames SHALL produce no bus_wr and no frame_err (a read header still issues its bus_rd).
REQ-029 ss fall while not in IDLE (glitch) SHALL be treated as ss rise followed by new frame.
REQ-030 bus_wr and bus_rd SHALL never be asserted in the same clock.

Reset
REQ-031 On rst: state IDLE, bit counter 0, bus_addr 0, bus_wr_data 0, bus_wr 0, bus_rd 0, miso 0, miso_oe 0, frame_err 0; synchronisers loaded with idle values (sck 1, ss 1, mosi 0).
REQ-032 rst mid-frame SHALL abort without bus_wr or frame_err; bridge SHALL resume only after a subsequent ss fall.

Verification
REQ-033 Write, defaults: header addr 0x3003, autoinc 0, RnW 0, wire data bytes 0x50,0x00 -> one bus_wr, bus_addr 0x3003, bus_wr_data 0x0050.
REQ-034 Read: header addr 0x3001, RnW 1, bus model returns 0xAAAA -> one bus_rd at 0x3001; miso shifts 0xAA then 0xAA; miso_oe high only during frame.
REQ-035 Burst write autoinc: addr 0x3FFE, 4 data words 1,2,3,4 -> bus_wr at 0x3FFE,0x3FFF,0x0000,0x0001 with data 1..4.
REQ-036 Burst read autoinc=0: addr 0x1000, 3 words, model returns incrementing values 0x0011,0x0022,0x0033 -> three bus_rd all at 0x1000; miso carries 0x11,0x00,0x22,0x00,0x33,0x00.
REQ-037 Abort: write header then 9 data bits, ss rise -> no bus_wr, frame_err one clock; next full write frame completes normally.
REQ-038 Reset mid-frame and DATA_WIDTH=32 rerun of REQ-033 with data 0x12345678 (wire 0x78,0x56,0x34,0x12) -> abort clean; bus_wr_data 0x12345678.
